// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all channels in reset for a minimum time, then releases
// them in order with per-channel delays, plus per-channel local reset stretching.
module rst_seq_ctrl #(
    parameter int N          = 8,
    parameter int DLY_W      = 8,
    parameter int MIN_ASSERT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      glob_req_i,
    input  logic [N-1:0]              req_i,
    input  logic [N-1:0][DLY_W-1:0]   dly_i,
    output logic [N-1:0]              rst_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int CNT_W = $clog2(MIN_ASSERT + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MIN_ASSERT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_RELEASE,
        S_IDLE
    } state_t;

    state_t                       state, state_n;
    logic [CNT_W-1:0]             cnt, cnt_n;
    logic [IDX_W-1:0]             idx, idx_n, idx_inc;
    logic [DLY_W-1:0]             dcnt, dcnt_n;
    logic [N-1:0]                 seq_hold, seq_hold_n;
    logic [N-1:0]                 lhold, lhold_n;
    logic [N-1:0][CNT_W-1:0]      lcnt, lcnt_n;
    logic                         done_n;

    // A global request always wins, including on the edge of the final release.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        dcnt_n     = dcnt;
        seq_hold_n = seq_hold;
        done_n     = 1'b0;
        idx_inc    = idx + IDX_W'(1);
        case (state)
            S_ASSERT: begin
                seq_hold_n = '1;
                if (glob_req_i) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_RELEASE;
                    idx_n   = '0;
                    dcnt_n  = dly_i[0];
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (glob_req_i) begin
                    state_n    = S_ASSERT;
                    seq_hold_n = '1;
                    cnt_n      = '0;
                end else if (dcnt != '0) begin
                    dcnt_n = dcnt - DLY_W'(1);
                end else begin
                    seq_hold_n[idx] = 1'b0;
                    if (idx < IDX_LAST) begin
                        idx_n  = idx_inc;
                        dcnt_n = dly_i[idx_inc];
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (glob_req_i) begin
                    state_n    = S_ASSERT;
                    seq_hold_n = '1;
                    cnt_n      = '0;
                end
            end
            default: begin
                state_n    = S_ASSERT;
                seq_hold_n = '1;
                cnt_n      = '0;
            end
        endcase
    end

    // Local holds stretch each request to MIN_ASSERT cycles after its last high sample.
    always_comb begin
        lhold_n = lhold;
        lcnt_n  = lcnt;
        for (int k = 0; k < N; k++) begin
            if (req_i[k]) begin
                lhold_n[k] = 1'b1;
                lcnt_n[k]  = CNT_INIT;
            end else if (lcnt[k] > CNT_ONE) begin
                lcnt_n[k] = lcnt[k] - CNT_ONE;
            end else if (lcnt[k] == CNT_ONE) begin
                lcnt_n[k]  = '0;
                lhold_n[k] = 1'b0;
            end
        end
    end

    // Outputs are registered from next-state values so they move on the deciding edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_ASSERT;
            cnt      <= '0;
            idx      <= '0;
            dcnt     <= '0;
            seq_hold <= '1;
            lhold    <= '0;
            lcnt     <= '0;
            rst_o    <= '1;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            dcnt     <= dcnt_n;
            seq_hold <= seq_hold_n;
            lhold    <= lhold_n;
            lcnt     <= lcnt_n;
            rst_o    <= seq_hold_n | lhold_n;
            busy_o   <= (state_n != S_IDLE);
            done_o   <= done_n;
        end
    end

endmodule
